// File: rtl/id_stage_if.sv
// Fetch/writeback/hazard inputs and decoded bundle outputs of the decode stage.
// The slave modport belongs to id_stage; the master modport belongs to the surrounding pipeline.
interface id_stage_if #(
    parameter int DSIZE = 16,
    parameter int ISIZE = 16,
    parameter int ASIZE = 4
);
    logic [ISIZE-1:0] inst_in;
    logic [DSIZE-1:0] pc_in;
    logic             flush_in;
    logic             exe_memtoreg_in;
    logic [ASIZE-1:0] exe_waddr_in;
    logic             wb_wen_in;
    logic [ASIZE-1:0] wb_waddr_in;
    logic [DSIZE-1:0] wb_wdata_in;

    logic             stall_out;
    logic [DSIZE-1:0] rdata1_out;
    logic [DSIZE-1:0] rdata2_out;
    logic [DSIZE-1:0] imm_out;
    logic [2:0]       opcode_out;
    logic             alusrc_out;
    logic             memwrite_out;
    logic             memtoreg_out;
    logic             writeenable_out;
    logic             branch_out;
    logic             unconditional_branch_out;
    logic [ASIZE-1:0] waddr_out;
    logic [DSIZE-1:0] PC_out;
    logic [ISIZE-1:0] INST_out;

    modport slave (
        input  inst_in, pc_in, flush_in, exe_memtoreg_in, exe_waddr_in,
               wb_wen_in, wb_waddr_in, wb_wdata_in,
        output stall_out, rdata1_out, rdata2_out, imm_out, opcode_out,
               alusrc_out, memwrite_out, memtoreg_out, writeenable_out,
               branch_out, unconditional_branch_out, waddr_out, PC_out, INST_out
    );

    modport master (
        output inst_in, pc_in, flush_in, exe_memtoreg_in, exe_waddr_in,
               wb_wen_in, wb_waddr_in, wb_wdata_in,
        input  stall_out, rdata1_out, rdata2_out, imm_out, opcode_out,
               alusrc_out, memwrite_out, memtoreg_out, writeenable_out,
               branch_out, unconditional_branch_out, waddr_out, PC_out, INST_out
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 16-entry register file with write-through bypass,
// instruction decode and load-use hazard detection.
module id_stage #(
    parameter int DSIZE = 16,
    parameter int ISIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus
);
    localparam int NREG = 2 ** ASIZE;

    logic             valid_q;
    logic [ISIZE-1:0] inst_q;
    logic [DSIZE-1:0] pc_q;
    logic [DSIZE-1:0] rf_q [NREG];

    logic [3:0]       op;
    logic [ASIZE-1:0] rd, rs, rt;
    logic [ASIZE-1:0] ra1, ra2;
    logic             use_rs, use_rt, use_rd;
    logic [2:0]       opcode_d;
    logic             alusrc_d, memwrite_d, memtoreg_d, wen_d, branch_d, ubranch_d;
    logic [DSIZE-1:0] imm_d;
    logic             stall;
    logic             bubble;

    assign op = inst_q[15:12];
    assign rd = inst_q[11:8];
    assign rs = inst_q[7:4];
    assign rt = inst_q[3:0];

    always_comb begin
        opcode_d   = 3'b000;
        alusrc_d   = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        wen_d      = 1'b0;
        branch_d   = 1'b0;
        ubranch_d  = 1'b0;
        imm_d      = '0;
        ra1        = rs;
        ra2        = rt;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        use_rd     = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                opcode_d = {1'b0, op[1:0]};
                wen_d    = 1'b1;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
            end
            4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                opcode_d = {1'b1, op[1:0]};
                alusrc_d = 1'b1;
                wen_d    = 1'b1;
                imm_d    = {{(DSIZE-4){1'b0}}, rt};
                use_rs   = 1'b1;
            end
            4'b1000: begin
                alusrc_d   = 1'b1;
                memtoreg_d = 1'b1;
                wen_d      = 1'b1;
                imm_d      = {{(DSIZE-4){rt[3]}}, rt};
                use_rs     = 1'b1;
            end
            4'b1001: begin
                ra2        = rd;
                alusrc_d   = 1'b1;
                memwrite_d = 1'b1;
                imm_d      = {{(DSIZE-4){rt[3]}}, rt};
                use_rs     = 1'b1;
                use_rd     = 1'b1;
            end
            4'b1100: begin
                // BEQ compares rd against rs, so rd goes out on port 1
                ra1      = rd;
                ra2      = rs;
                opcode_d = 3'b001;
                branch_d = 1'b1;
                imm_d    = {{(DSIZE-4){rt[3]}}, rt};
                use_rs   = 1'b1;
                use_rd   = 1'b1;
            end
            4'b1110: begin
                ubranch_d = 1'b1;
                imm_d     = {{(DSIZE-12){inst_q[11]}}, inst_q[11:0]};
            end
            default: ;
        endcase
    end

    assign stall = valid_q && bus.exe_memtoreg_in && !bus.flush_in &&
                   (bus.exe_waddr_in != '0) &&
                   ((use_rs && bus.exe_waddr_in == rs) ||
                    (use_rt && bus.exe_waddr_in == rt) ||
                    (use_rd && bus.exe_waddr_in == rd));
    assign bubble = !valid_q || stall || bus.flush_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (bus.flush_in) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= 1'b1;
            inst_q  <= bus.inst_in;
            pc_q    <= bus.pc_in;
        end
    end

    // Writeback keeps writing through a stall; r0 is never stored
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (bus.wb_wen_in && bus.wb_waddr_in != '0) begin
            rf_q[bus.wb_waddr_in] <= bus.wb_wdata_in;
        end
    end

    always_comb begin
        if (ra1 == '0)                                      bus.rdata1_out = '0;
        else if (bus.wb_wen_in && bus.wb_waddr_in == ra1)   bus.rdata1_out = bus.wb_wdata_in;
        else                                                bus.rdata1_out = rf_q[ra1];
        if (ra2 == '0)                                      bus.rdata2_out = '0;
        else if (bus.wb_wen_in && bus.wb_waddr_in == ra2)   bus.rdata2_out = bus.wb_wdata_in;
        else                                                bus.rdata2_out = rf_q[ra2];
    end

    assign bus.stall_out                = stall;
    assign bus.imm_out                  = imm_d;
    assign bus.opcode_out               = bubble ? 3'b000 : opcode_d;
    assign bus.alusrc_out               = !bubble && alusrc_d;
    assign bus.memwrite_out             = !bubble && memwrite_d;
    assign bus.memtoreg_out             = !bubble && memtoreg_d;
    assign bus.writeenable_out          = !bubble && wen_d;
    assign bus.branch_out               = !bubble && branch_d;
    assign bus.unconditional_branch_out = !bubble && ubranch_d;
    assign bus.waddr_out                = (!bubble && wen_d) ? rd : '0;
    assign bus.PC_out                   = pc_q;
    assign bus.INST_out                 = inst_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, bypass, load-use stall, flush, immediates, r0.
module tb_id_stage;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    id_stage_if #(.DSIZE(16), .ISIZE(16), .ASIZE(4)) bus ();

    id_stage #(.DSIZE(16), .ISIZE(16), .ASIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        bus.inst_in = '0; bus.pc_in = '0; bus.flush_in = 1'b0;
        bus.exe_memtoreg_in = 1'b0; bus.exe_waddr_in = '0;
        bus.wb_wen_in = 1'b0; bus.wb_waddr_in = '0; bus.wb_wdata_in = '0;
        tick(); tick();
        #1;
        chk("rst_stall", bus.stall_out, 0);
        chk("rst_wen", bus.writeenable_out, 0);
        chk("rst_rdata1", bus.rdata1_out, 0);
        chk("rst_pc", bus.PC_out, 0);
        chk("rst_inst", bus.INST_out, 0);

        // Fill r2=5, r3=7 and fetch ADD r1,r2,r3
        rst = 1'b1;
        bus.wb_wen_in = 1'b1; bus.wb_waddr_in = 4'd2; bus.wb_wdata_in = 16'd5;
        tick();
        bus.wb_waddr_in = 4'd3; bus.wb_wdata_in = 16'd7;
        bus.inst_in = 16'h0123; bus.pc_in = 16'h0040;
        tick();
        bus.wb_wen_in = 1'b0;
        #1;
        chk("add_opcode", bus.opcode_out, 3'b000);
        chk("add_rdata1", bus.rdata1_out, 16'd5);
        chk("add_rdata2", bus.rdata2_out, 16'd7);
        chk("add_wen", bus.writeenable_out, 1);
        chk("add_waddr", bus.waddr_out, 4'd1);
        chk("add_pc", bus.PC_out, 16'h0040);
        chk("add_alusrc", bus.alusrc_out, 0);

        bus.wb_wen_in = 1'b1; bus.wb_waddr_in = 4'd3; bus.wb_wdata_in = 16'd9;
        #1;
        chk("bypass_rdata2", bus.rdata2_out, 16'd9);
        tick();
        bus.wb_wen_in = 1'b0;

        // Load-use on SUB r4,r1,r5
        bus.inst_in = 16'h1415; bus.pc_in = 16'h0042;
        tick();
        bus.exe_memtoreg_in = 1'b1; bus.exe_waddr_in = 4'd1;
        bus.inst_in = 16'h2000; bus.pc_in = 16'h0044;
        #1;
        chk("lu_stall", bus.stall_out, 1);
        chk("lu_bubble_wen", bus.writeenable_out, 0);
        chk("lu_bubble_waddr", bus.waddr_out, 0);
        chk("lu_bubble_opc", bus.opcode_out, 0);
        tick();
        bus.exe_memtoreg_in = 1'b0;
        #1;
        chk("lu_release", bus.stall_out, 0);
        chk("lu_inst_held", bus.INST_out, 16'h1415);
        chk("lu_pc_held", bus.PC_out, 16'h0042);
        chk("lu_sub_opc", bus.opcode_out, 3'b001);
        chk("lu_sub_waddr", bus.waddr_out, 4'd4);
        tick();
        chk("lu_next_inst", bus.INST_out, 16'h2000);

        // SLL r6,r2,7: rt is not a source
        bus.inst_in = 16'h4627; bus.pc_in = 16'h0046;
        tick();
        bus.exe_memtoreg_in = 1'b1; bus.exe_waddr_in = 4'd7;
        #1;
        chk("sll_rt_nostall", bus.stall_out, 0);
        chk("sll_opcode", bus.opcode_out, 3'b100);
        chk("sll_imm", bus.imm_out, 16'h0007);
        chk("sll_alusrc", bus.alusrc_out, 1);
        chk("sll_rdata1", bus.rdata1_out, 16'd5);
        chk("sll_waddr", bus.waddr_out, 4'd6);
        bus.exe_waddr_in = 4'd0;
        #1;
        chk("r0_load_nostall", bus.stall_out, 0);
        bus.exe_waddr_in = 4'd2;
        #1;
        chk("sll_rs_stall", bus.stall_out, 1);

        bus.flush_in = 1'b1;
        #1;
        chk("flush_nostall", bus.stall_out, 0);
        chk("flush_wen", bus.writeenable_out, 0);
        chk("flush_alusrc", bus.alusrc_out, 0);
        tick();
        bus.flush_in = 1'b0;
        #1;
        chk("postflush_stall", bus.stall_out, 0);
        chk("postflush_wen", bus.writeenable_out, 0);
        chk("postflush_alusrc", bus.alusrc_out, 0);
        chk("postflush_waddr", bus.waddr_out, 0);
        bus.exe_memtoreg_in = 1'b0;

        // SW r10 -> [r3 + -1]
        bus.inst_in = 16'h9A3F; bus.pc_in = 16'h0048;
        tick();
        chk("sw_imm", bus.imm_out, 16'hFFFF);
        chk("sw_memwrite", bus.memwrite_out, 1);
        chk("sw_wen", bus.writeenable_out, 0);
        chk("sw_waddr", bus.waddr_out, 0);
        chk("sw_base", bus.rdata1_out, 16'd9);
        chk("sw_data", bus.rdata2_out, 16'd0);

        bus.inst_in = 16'hE800; bus.pc_in = 16'h004A;
        tick();
        chk("j_imm", bus.imm_out, 16'hF800);
        chk("j_ub", bus.unconditional_branch_out, 1);
        chk("j_wen", bus.writeenable_out, 0);

        bus.inst_in = 16'hC230; bus.pc_in = 16'h004C;
        tick();
        chk("beq_branch", bus.branch_out, 1);
        chk("beq_opcode", bus.opcode_out, 3'b001);
        chk("beq_rdata1", bus.rdata1_out, 16'd5);
        chk("beq_rdata2", bus.rdata2_out, 16'd9);
        chk("beq_imm", bus.imm_out, 16'h0000);
        bus.exe_memtoreg_in = 1'b1; bus.exe_waddr_in = 4'd2;
        #1;
        chk("beq_rd_stall", bus.stall_out, 1);
        bus.exe_memtoreg_in = 1'b0;

        bus.inst_in = 16'h8F2E; bus.pc_in = 16'h004E;
        tick();
        chk("lw_imm", bus.imm_out, 16'hFFFE);
        chk("lw_memtoreg", bus.memtoreg_out, 1);
        chk("lw_waddr", bus.waddr_out, 4'hF);
        chk("lw_rdata1", bus.rdata1_out, 16'd5);

        // r0 never written nor bypassed
        bus.inst_in = 16'h1000;
        tick();
        bus.wb_wen_in = 1'b1; bus.wb_waddr_in = 4'd0; bus.wb_wdata_in = 16'h1234;
        #1;
        chk("r0_no_bypass", bus.rdata1_out, 0);
        tick();
        bus.wb_wen_in = 1'b0;
        #1;
        chk("r0_still_zero", bus.rdata1_out, 0);

        // Reset in the middle of a stall
        bus.inst_in = 16'h1415;
        tick();
        bus.exe_memtoreg_in = 1'b1; bus.exe_waddr_in = 4'd1;
        #1;
        chk("pre_rst_stall", bus.stall_out, 1);
        rst = 1'b0;
        tick();
        chk("rst_mid_stall", bus.stall_out, 0);
        chk("rst_mid_inst", bus.INST_out, 0);
        chk("rst_mid_pc", bus.PC_out, 0);
        rst = 1'b1;
        bus.exe_memtoreg_in = 1'b0;
        bus.inst_in = 16'h0023;
        tick();
        chk("rf_cleared", bus.rdata1_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
